priority_code_decoder: RTL and testbench
========================================

// Module: priority_code_decoder
// PURPOSE
//  Inverse of the 4-slot priority encoder. Accepts code words {none, index} over a
//  valid/ready handshake and expands each into a canonical set of four 2-bit slots.
//  Round-trip rule: re-encoding the decoded slots returns the original code.
//  Decoded words pass through a 2-entry FIFO with valid/ready on the output side.
//  The block also keeps wrapping statistics counters and a sticky protocol-error flag.
// PARAMETERS
//  LOW_FILL   2'd0  value driven on slots below the selected index; must not be 2'd1
//  HIGH_FILL  2'd0  value driven on slots above the selected index; must not be 2'd1
//  CNT_W      16    width of code_count and none_count
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      code word present
//  in_ready    out  1      FIFO can accept; equals !full
//  in_index    in   2      index of highest slot equal to 1
//  in_none     in   1      1 = no slot equal to 1
//  out_valid   out  1      decoded word present; equals !empty
//  out_ready   in   1      consumer accepts the head word
//  out_slot_0  out  2      decoded slot 0, FIFO head
//  out_slot_1  out  2      decoded slot 1, FIFO head
//  out_slot_2  out  2      decoded slot 2, FIFO head
//  out_slot_3  out  2      decoded slot 3, FIFO head
//  code_count  out  CNT_W  accepted code words, wraps at 2^CNT_W
//  none_count  out  CNT_W  accepted words with in_none=1, wraps
//  proto_err   out  1      sticky: accepted word with in_none=1 and in_index!=0
//  err_clr     in   1      synchronous clear of proto_err
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - FIFO empty: out_valid=0, in_ready=1.
//   - out_slot_0..3=0, code_count=0, none_count=0, proto_err=0.
//  Handshakes:
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - The producer holds in_index and in_none stable while in_valid=1 and in_ready=0.
//  Decode of one accepted word (index k):
//   - slot k = 2'd1; slots j>k = HIGH_FILL; slots j<k = LOW_FILL.
//   - If in_none=1, all slots = LOW_FILL, regardless of index.
//  FIFO (2 entries, registered occupancy 0..2; no combinational in->out path):
//   - Latency: a word pushed at edge N into an empty FIFO gives out_valid=1 after N.
//   - out_slot_* show the head entry and stay stable while out_valid=1 and out_ready=0.
//   - When out_valid=0, out_slot_* hold their last value.
//   - Occupancy 1 with push and pop in the same cycle: occupancy stays 1 and the new
//     word becomes head.
//   - Occupancy 2 (full): in_ready=0, so no push; a pop that cycle leaves occupancy 1
//     and in_ready rises next cycle.
//   - Occupancy 0: a pop cannot occur because out_valid=0.
//   - Full throughput: 1 word/cycle when out_ready is held at 1.
//  Counters (update on push only):
//   - code_count += 1; none_count += in_none; both wrap from all-ones to 0.
//  proto_err:
//   - Set on a push with in_none=1 and in_index!=0.
//   - err_clr=1 clears it; a set in the same cycle wins over the clear.
//  Reset mid-operation: FIFO contents discarded, all outputs return to reset values.
// TESTING
//  1. Push idx=2, none=0, out_ready=1 -> next cycle out_valid=1, slots{3,2,1,0}=
//     {0,1,0,0}; code_count=1.
//  2. LOW_FILL=3, HIGH_FILL=2: push idx=1 -> slots{3,2,1,0}={2,2,1,3}. Re-encode with
//     the priority encoder -> 1 for all 4 indices.
//  3. out_ready=0, push 3 words back to back -> in_ready falls after the 2nd push;
//     the 3rd is held. Raise out_ready -> words emerge in order with no loss or duplicate.
//  4. Occupancy 1, push and pop in the same cycle for 10 cycles -> occupancy stays 1
//     and out_slot_* track each word one cycle later.
//  5. Push none=1, idx=3 -> slots all LOW_FILL, none_count=1, proto_err=1. err_clr
//     pulse -> 0. Push none=1, idx=3 with err_clr=1 in the same cycle -> proto_err=1.
//  6. Preload code_count=16'hFFFF via 65535 pushes, then 1 more push -> 0.
//     Assert rst_n=0 mid-stream with the FIFO full -> out_valid=0 and counters=0
//     immediately.

Source files
------------

// File: rtl/priority_code_decoder.sv
// priority_code_decoder: expands {none, index} code words into four 2-bit slots
// and queues them in a 2-entry FIFO. It also keeps wrapping push counters and a
// sticky protocol-error flag.
module priority_code_decoder #(
    parameter logic [1:0] LOW_FILL  = 2'd0,
    parameter logic [1:0] HIGH_FILL = 2'd0,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_index,
    input  logic             in_none,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_slot_0,
    output logic [1:0]       out_slot_1,
    output logic [1:0]       out_slot_2,
    output logic [1:0]       out_slot_3,
    output logic [CNT_W-1:0] code_count,
    output logic [CNT_W-1:0] none_count,
    output logic             proto_err,
    input  logic             err_clr
);

    // Packed word layout is {slot3, slot2, slot1, slot0}. The fills must never
    // be 2'd1, so re-encoding the slots returns the original code.
    function automatic logic [7:0] decode_word(input logic [1:0] index, input logic none);
        logic [7:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            if (none)
                w[2*j +: 2] = LOW_FILL;
            else if (j == int'(index))
                w[2*j +: 2] = 2'd1;
            else if (j > int'(index))
                w[2*j +: 2] = HIGH_FILL;
            else
                w[2*j +: 2] = LOW_FILL;
        end
        return w;
    endfunction

    logic [7:0] word_p0;
    logic [7:0] head_p1;
    logic [7:0] tail_p1;
    logic [1:0] occ_p1;
    logic       push;
    logic       pop;

    // Stage 0: combinational decode of the incoming code word
    assign word_p0   = decode_word(in_index, in_none);
    assign in_ready  = (occ_p1 != 2'd2);
    assign out_valid = (occ_p1 != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Stage 1: FIFO storage. The head register drives the outputs directly, so
    // the slots hold their last value when the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_p1  <= 2'd0;
            head_p1 <= '0;
            tail_p1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_p1 == 2'd0)
                        head_p1 <= word_p0;
                    else
                        tail_p1 <= word_p0;
                    occ_p1 <= occ_p1 + 2'd1;
                end
                2'b01: begin
                    if (occ_p1 == 2'd2)
                        head_p1 <= tail_p1;
                    occ_p1 <= occ_p1 - 2'd1;
                end
                // Push and pop together only happens at occupancy 1, because
                // full blocks the push and empty blocks the pop.
                2'b11: head_p1 <= word_p0;
                default: ;
            endcase
        end
    end

    assign out_slot_0 = head_p1[1:0];
    assign out_slot_1 = head_p1[3:2];
    assign out_slot_2 = head_p1[5:4];
    assign out_slot_3 = head_p1[7:6];

    // Statistics counters, advanced on accepted words only, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_count <= '0;
            none_count <= '0;
        end else if (push) begin
            code_count <= code_count + {{(CNT_W-1){1'b0}}, 1'b1};
            none_count <= none_count + {{(CNT_W-1){1'b0}}, in_none};
        end
    end

    // Sticky error: a contradictory word (none with nonzero index) beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            proto_err <= 1'b0;
        else if (push && in_none && (in_index != 2'd0))
            proto_err <= 1'b1;
        else if (err_clr)
            proto_err <= 1'b0;
    end

endmodule

// File: tb/tb_priority_code_decoder.sv
// Directed testbench for priority_code_decoder. It drives two instances: one
// with the default zero fills and one with LOW_FILL=3 and HIGH_FILL=2.
module tb_priority_code_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_index;
    logic        in_none;
    logic        out_ready;
    logic        err_clr;

    logic        a_in_ready, a_out_valid, a_proto_err;
    logic [1:0]  a_s0, a_s1, a_s2, a_s3;
    logic [15:0] a_code_count, a_none_count;

    logic        b_in_ready, b_out_valid, b_proto_err;
    logic [1:0]  b_s0, b_s1, b_s2, b_s3;
    logic [15:0] b_code_count, b_none_count;

    logic [7:0]  a_word, b_word;
    assign a_word = {a_s3, a_s2, a_s1, a_s0};
    assign b_word = {b_s3, b_s2, b_s1, b_s0};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    priority_code_decoder #(.LOW_FILL(2'd0), .HIGH_FILL(2'd0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_index(in_index), .in_none(in_none), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_slot_0(a_s0), .out_slot_1(a_s1),
        .out_slot_2(a_s2), .out_slot_3(a_s3), .code_count(a_code_count),
        .none_count(a_none_count), .proto_err(a_proto_err), .err_clr(err_clr)
    );

    priority_code_decoder #(.LOW_FILL(2'd3), .HIGH_FILL(2'd2), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_index(in_index), .in_none(in_none), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_slot_0(b_s0), .out_slot_1(b_s1),
        .out_slot_2(b_s2), .out_slot_3(b_s3), .code_count(b_code_count),
        .none_count(b_none_count), .proto_err(b_proto_err), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference 4-slot priority encoder: {none, index} of the highest slot equal to 1
    function automatic logic [2:0] encode(input logic [7:0] w);
        logic [2:0] r;
        r = 3'b100;
        for (int j = 0; j < 4; j++)
            if (w[2*j +: 2] == 2'd1) r = {1'b0, j[1:0]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];

    initial begin
        exp_a[0] = 8'h01; exp_a[1] = 8'h04; exp_a[2] = 8'h10; exp_a[3] = 8'h40;
        exp_b[0] = 8'hA9; exp_b[1] = 8'hA7; exp_b[2] = 8'h9F; exp_b[3] = 8'h7F;

        rst_n = 1'b0; in_valid = 1'b0; in_index = 2'd0; in_none = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;
        tick(); tick();
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd1);
        check("rst_slots", 32'(a_word), 32'h0);
        check("rst_code_count", 32'(a_code_count), 32'd0);
        check("rst_none_count", 32'(a_none_count), 32'd0);
        check("rst_proto_err", 32'(a_proto_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single word, one-cycle latency, then drain and hold
        out_ready = 1'b1; in_valid = 1'b1; in_index = 2'd2; in_none = 1'b0;
        tick();
        in_valid = 1'b0;
        check("t1_out_valid", 32'(a_out_valid), 32'd1);
        check("t1_slots", 32'(a_word), 32'h10);
        check("t1_code_count", 32'(a_code_count), 32'd1);
        check("t1_slots_fill", 32'(b_word), 32'h9F);
        tick();
        check("t1_drained", 32'(a_out_valid), 32'd0);
        check("t1_hold", 32'(a_word), 32'h10);

        // All indices back to back; fill values and round-trip re-encode
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_index = 2'(i);
            tick();
            check("t2_slots_default", 32'(a_word), 32'(exp_a[i]));
            check("t2_slots_fill", 32'(b_word), 32'(exp_b[i]));
            check("t2_reencode", 32'(encode(b_word)), i);
        end
        in_valid = 1'b0;
        tick();
        check("t2_drained", 32'(a_out_valid), 32'd0);
        check("t2_code_count", 32'(a_code_count), 32'd5);

        // Backpressure: third word held until the consumer drains
        out_ready = 1'b0; in_valid = 1'b1; in_index = 2'd0;
        tick();
        check("t3_ready_occ1", 32'(a_in_ready), 32'd1);
        in_index = 2'd1;
        tick();
        check("t3_ready_full", 32'(a_in_ready), 32'd0);
        check("t3_head_A", 32'(a_word), 32'h01);
        in_index = 2'd3;
        tick();
        check("t3_still_full", 32'(a_in_ready), 32'd0);
        check("t3_head_hold", 32'(a_word), 32'h01);
        check("t3_count_held", 32'(a_code_count), 32'd7);
        out_ready = 1'b1;
        tick();
        check("t3_head_B", 32'(a_word), 32'h04);
        check("t3_ready_back", 32'(a_in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t3_head_C", 32'(a_word), 32'h40);
        check("t3_count_C", 32'(a_code_count), 32'd8);
        tick();
        check("t3_drained", 32'(a_out_valid), 32'd0);

        // Occupancy 1 with simultaneous push and pop for 10 cycles
        in_valid = 1'b1; in_index = 2'd0;
        tick();
        for (int i = 0; i < 10; i++) begin
            in_index = 2'((i + 1) % 4);
            tick();
            check("t4_valid", 32'(a_out_valid), 32'd1);
            check("t4_ready", 32'(a_in_ready), 32'd1);
            check("t4_slots", 32'(a_word), 32'(exp_a[(i + 1) % 4]));
        end
        in_valid = 1'b0;
        tick();
        check("t4_drained", 32'(a_out_valid), 32'd0);
        check("t4_code_count", 32'(a_code_count), 32'd19);

        // none words and the sticky error flag
        in_valid = 1'b1; in_none = 1'b1; in_index = 2'd3;
        tick();
        in_valid = 1'b0;
        check("t5_slots_low", 32'(a_word), 32'h00);
        check("t5_slots_low_fill", 32'(b_word), 32'hFF);
        check("t5_none_count", 32'(a_none_count), 32'd1);
        check("t5_err_set", 32'(a_proto_err), 32'd1);
        err_clr = 1'b1;
        tick();
        check("t5_err_clr", 32'(a_proto_err), 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t5_set_wins", 32'(a_proto_err), 32'd1);
        check("t5_none_count2", 32'(a_none_count), 32'd2);
        tick();
        err_clr = 1'b0;
        check("t5_err_clr2", 32'(a_proto_err), 32'd0);
        in_valid = 1'b1; in_index = 2'd0;
        tick();
        in_valid = 1'b0; in_none = 1'b0;
        check("t5_idx0_no_err", 32'(a_proto_err), 32'd0);
        check("t5_none_count3", 32'(a_none_count), 32'd3);
        check("t5_code_count", 32'(a_code_count), 32'd22);

        // Counter wrap: 65513 more pushes reach all-ones, one more wraps to 0
        in_valid = 1'b1; in_index = 2'd0;
        repeat (65513) tick();
        check("t6_count_max", 32'(a_code_count), 32'hFFFF);
        tick();
        check("t6_count_wrap", 32'(a_code_count), 32'd0);

        // Fill the FIFO with an error word, then reset asynchronously mid-cycle
        out_ready = 1'b0; in_none = 1'b1; in_index = 2'd1;
        tick();
        in_none = 1'b0;
        tick();
        in_valid = 1'b0;
        check("t6_full", 32'(a_in_ready), 32'd0);
        check("t6_err_before", 32'(a_proto_err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(a_out_valid), 32'd0);
        check("t6_rst_ready", 32'(a_in_ready), 32'd1);
        check("t6_rst_code", 32'(a_code_count), 32'd0);
        check("t6_rst_none", 32'(a_none_count), 32'd0);
        check("t6_rst_err", 32'(a_proto_err), 32'd0);
        check("t6_rst_slots", 32'(a_word), 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
